// File: rtl/brush_stamper.sv
// Square brush stamper: writes a clipped (2S+1)x(2S+1) block, or the whole screen,
// into a palette-index frame buffer in raster order, one pixel per non-held cycle.
module brush_stamper #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic        iCMD_VALID,
  output logic        oCMD_READY,
  input  logic        iCLEAR,
  input  logic [9:0]  iX,
  input  logic [8:0]  iY,
  input  logic [3:0]  iSIZE,
  input  logic [7:0]  iCOLOR,
  input  logic        iHOLD,
  output logic        oWREN,
  output logic [18:0] oADDR,
  output logic [7:0]  oDATA,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam logic [9:0]  XMax   = 10'(H_RES - 1);
  localparam logic [8:0]  YMax   = 9'(V_RES - 1);
  localparam logic [18:0] RowInc = 19'(H_RES);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_t;

  state_t      r_state;
  logic        r_ready, r_fill, r_busy, r_done, r_clr;
  logic [9:0]  r_x, r_x0, r_x1, r_cx;
  logic [8:0]  r_y, r_y1, r_cy;
  logic [3:0]  r_s;
  logic [7:0]  r_data;
  logic [18:0] r_addr, r_row;

  logic [10:0] w_xe;
  logic [9:0]  w_ye;
  logic [9:0]  w_x0, w_x1;
  logic [8:0]  w_y0, w_y1;
  logic        w_oob;
  logic [18:0] w_row0;

  // Bounds are computed in widened arithmetic so neither edge can wrap.
  always_comb begin
    w_xe   = {1'b0, r_x} + 11'(r_s);
    w_ye   = {1'b0, r_y} + 10'(r_s);
    w_x0   = (10'(r_s) > r_x) ? 10'd0 : r_x - 10'(r_s);
    w_y0   = (9'(r_s) > r_y) ? 9'd0 : r_y - 9'(r_s);
    w_x1   = (w_xe > {1'b0, XMax}) ? XMax : w_xe[9:0];
    w_y1   = (w_ye > {1'b0, YMax}) ? YMax : w_ye[8:0];
    w_oob  = ({1'b0, r_x} >= 11'(H_RES)) || ({1'b0, r_y} >= 10'(V_RES));
    if (r_clr) begin
      w_x0  = 10'd0;
      w_x1  = XMax;
      w_y0  = 9'd0;
      w_y1  = YMax;
      w_oob = 1'b0;
    end
    // Row base multiply happens once per command, never per pixel.
    w_row0 = 19'(w_y0) * RowInc;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
      r_fill  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      r_data  <= 8'd0;
      r_addr  <= 19'd0;
      r_row   <= 19'd0;
      r_x     <= 10'd0;
      r_y     <= 9'd0;
      r_s     <= 4'd0;
      r_x0    <= 10'd0;
      r_x1    <= 10'd0;
      r_y1    <= 9'd0;
      r_cx    <= 10'd0;
      r_cy    <= 9'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (r_ready && iCMD_VALID) begin
            r_x     <= iX;
            r_y     <= iY;
            r_s     <= iSIZE;
            r_clr   <= iCLEAR;
            r_data  <= iCOLOR;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StSetup;
          end else begin
            r_ready <= 1'b1;
          end
        end
        StSetup: begin
          if (w_oob) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_x0    <= w_x0;
            r_x1    <= w_x1;
            r_y1    <= w_y1;
            r_cx    <= w_x0;
            r_cy    <= w_y0;
            r_row   <= w_row0;
            r_addr  <= w_row0 + 19'(w_x0);
            r_fill  <= 1'b1;
            r_state <= StFill;
          end
        end
        StFill: begin
          if (!iHOLD) begin
            if (r_cx == r_x1) begin
              if (r_cy == r_y1) begin
                r_fill  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= StDone;
              end else begin
                r_cx   <= r_x0;
                r_cy   <= r_cy + 9'd1;
                r_row  <= r_row + RowInc;
                r_addr <= r_row + RowInc + 19'(r_x0);
              end
            end else begin
              r_cx   <= r_cx + 10'd1;
              r_addr <= r_addr + 19'd1;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Hold gates the write immediately; position only advances on unheld cycles.
  assign oWREN      = r_fill && !iHOLD;
  assign oADDR      = r_addr;
  assign oDATA      = r_data;
  assign oBUSY      = r_busy;
  assign oDONE      = r_done;
  assign oCMD_READY = r_ready;

endmodule
